// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               fetch entry layout, NOP encoding and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Data/address width of the fetch path
    localparam int REG_BITS = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0)
    localparam logic [REG_BITS-1:0] NOP = 32'h0000_0013;

    // One buffered fetch: byte address plus the instruction word found there
    typedef struct packed {
        logic [REG_BITS-1:0] pc;
        logic [REG_BITS-1:0] instr;
    } fetch_entry_t;

    // Counters must represent 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's instruction-memory bus, redirect
//               input and downstream valid/ready instruction stream.
//               master = fetch unit side, slave = memory/pipeline side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if import fetch_unit_pkg::*; ();

    // Instruction memory request/response
    logic                imem_req_o;
    logic [REG_BITS-1:0] imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [REG_BITS-1:0] imem_rdata_i;

    // Control-flow redirect from the execute stage
    logic                redirect_i;
    logic [REG_BITS-1:0] redirect_pc_i;

    // Instruction stream towards decode
    logic                instr_valid_o;
    logic                instr_ready_i;
    logic [REG_BITS-1:0] instr_o;
    logic [REG_BITS-1:0] pc_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, pc_o,
        output instr_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered storage, synchronous flush
//               and occupancy count. Head is read straight from storage.
//               Push is accepted when full only if a pop happens alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  i_push,
    input  wire logic [WIDTH-1:0]      i_data,
    input  wire logic                  i_pop,
    input  wire logic                  i_flush,
    output logic      [WIDTH-1:0]      o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic      [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; cleared on reset so the head reads as zero when idle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; flush discards everything at once
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the fetch PC, issues word reads
//               to a variable-latency in-order instruction memory, buffers
//               returned words with their PC and streams them downstream.
//               A redirect flushes buffered words and drops every in-flight
//               response before restarting at the new target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int                  DEPTH        = 4,
    parameter logic [REG_BITS-1:0] RESET_VECTOR = '0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    fetch_unit_if.master bus
);

    localparam int                  c_cnt_w      = cnt_width(DEPTH);
    localparam logic [c_cnt_w:0]    c_credit_max = (c_cnt_w + 1)'(DEPTH);
    localparam logic [REG_BITS-1:0] c_pc_step    = REG_BITS'(4);

    // Architectural bookkeeping
    logic [REG_BITS-1:0] r_fetch_pc;     // next address to request
    logic [REG_BITS-1:0] r_resp_pc;      // address of the next kept response
    logic [c_cnt_w-1:0]  r_outstanding;  // granted but not yet returned
    logic [c_cnt_w-1:0]  r_discard;      // returns still to be thrown away
    logic                r_run;          // holds requests off while in reset

    logic [REG_BITS-1:0] w_target;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_cnt_w:0]    w_inflight;
    logic [c_cnt_w-1:0]  w_out_next;
    logic                w_credit;
    logic                w_req;
    logic                w_issue;
    logic                w_drop;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    // Redirect targets are word aligned; the low bits are ignored
    assign w_target = {bus.redirect_pc_i[REG_BITS-1:2], 2'b00};
    assign w_unused = &{1'b0, bus.redirect_pc_i[1:0]};

    // A slot is reserved per request at issue time, so buffered plus
    // in-flight words can never exceed the FIFO capacity
    assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_credit   = (w_inflight < c_credit_max);
    assign w_req      = r_run & ~bus.redirect_i & w_credit;
    assign w_issue    = w_req & bus.imem_gnt_i;

    // Responses belonging to a pre-redirect stream are dropped in order
    assign w_drop     = bus.imem_rvalid_i & (r_discard != '0) & ~bus.redirect_i;
    assign w_push     = bus.imem_rvalid_i & (r_discard == '0) & ~bus.redirect_i;
    assign w_pop      = ~w_fifo_empty & bus.instr_ready_i & ~bus.redirect_i;

    // Responses leave, issues arrive; both in one cycle cancel out
    assign w_out_next = r_outstanding + c_cnt_w'(w_issue) - c_cnt_w'(bus.imem_rvalid_i);

    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = bus.imem_rdata_i;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_i),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = r_fetch_pc;
    assign bus.instr_valid_o = ~w_fifo_empty;
    assign bus.instr_o       = w_head.instr;
    assign bus.pc_o          = w_head.pc;

    // PC tracking and in-flight/discard accounting; redirect takes priority
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc    <= RESET_VECTOR;
            r_resp_pc     <= RESET_VECTOR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_run         <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_out_next;
            if (bus.redirect_i) begin
                // Every request still outstanding after this cycle is stale
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= w_out_next;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_pc_step;
                end
                if (w_drop) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    // Memory must never return data that was not requested
    a_rvalid_requested: assert property (
        @(posedge clk_i) disable iff (!rst_i)
        bus.imem_rvalid_i |-> (r_outstanding != '0)
    );

    // Credit accounting guarantees a push into a full FIFO only alongside a pop
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_i)
        (w_push && w_fifo_full) |-> w_pop
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An in-order memory model
//               with random latency and a program-order reference (each
//               stream starts at the last redirect target and advances by 4)
//               check every issued address and every consumed instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit #(
        .DEPTH        (DEPTH),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outstanding memory request: address, stream epoch and earliest return cycle
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    // Directed redirect-alignment vectors
    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    req_t        pend[$];
    vec_t        vecs[4];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          epoch;
    int          fifo_cnt;
    int          since_rst;
    int          lat_max;
    int          n_issue;
    int          n_pop;
    int          first_issue_cyc;
    int          first_valid_cyc;
    int          cyc0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] first_pop_pc;

    // Contents of the instruction memory at a given address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the reference
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                        input logic gnt, input logic rv_allow);
        logic        rv;
        logic        issue;
        logic        pop;
        logic        kept;
        logic        credit_ok;
        logic [31:0] rd;
        req_t        ent;
        rv = 1'b0;
        rd = 32'h0;
        if (rv_allow && pend.size() > 0) begin
            if (cyc >= pend[0].due) begin
                rv = 1'b1;
                rd = mem_word(pend[0].addr);
            end
        end
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.instr_ready_i = rdy;
        bus.imem_gnt_i    = gnt;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rd;
        #1;
        credit_ok = !redir && ((fifo_cnt + pend.size()) < DEPTH);
        chk("instr_valid", {31'b0, bus.instr_valid_o}, {31'b0, fifo_cnt != 0});
        if (since_rst >= 1) begin
            chk("imem_req", {31'b0, bus.imem_req_o}, {31'b0, credit_ok});
        end else begin
            chk("imem_req_credit", {31'b0, bus.imem_req_o && !credit_ok}, 32'h0);
        end
        issue = bus.imem_req_o && gnt;
        pop   = bus.instr_valid_o && rdy && !redir;
        if (issue) begin
            chk("imem_addr", bus.imem_addr_o, exp_fetch);
            n_issue++;
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
        end
        if (bus.instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop) begin
            chk("pc_o", bus.pc_o, exp_pc);
            chk("instr_o", bus.instr_o, mem_word(exp_pc));
            if (n_pop == 0) first_pop_pc = bus.pc_o;
            n_pop++;
            exp_pc += 32'd4;
        end
        kept = 1'b0;
        if (rv) begin
            ent  = pend.pop_front();
            kept = !redir && (ent.epoch == epoch);
        end
        if (issue) begin
            ent.addr  = exp_fetch;
            ent.epoch = epoch;
            ent.due   = cyc + int'($urandom_range(1, lat_max));
            if (pend.size() > 0 && ent.due < pend[$].due) ent.due = pend[$].due;
            pend.push_back(ent);
            exp_fetch += 32'd4;
        end
        if (redir) begin
            fifo_cnt  = 0;
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end else begin
            fifo_cnt = fifo_cnt + int'(kept) - int'(pop);
        end
        @(posedge clk);
        #1;
        cyc++;
        since_rst++;
    endtask

    // Assert reset asynchronously, check reset values, then release
    task automatic apply_reset(input int hold);
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        #1;
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid_o}, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        pend.delete();
        fifo_cnt  = 0;
        exp_fetch = 32'h0;
        exp_pc    = 32'h0;
        repeat (hold) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        since_rst = 0;
    endtask

    // Redirect to rpc and let every in-flight response return
    task automatic drain(input logic [31:0] rpc);
        step(1'b1, rpc, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 60 && (pend.size() > 0 || fifo_cnt > 0); i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        chk("drain_left", pend.size() + fifo_cnt, 32'h0);
    endtask

    // Run with an eager memory until one instruction is consumed
    task automatic run_until_pop();
        n_pop = 0;
        for (int i = 0; i < 30 && n_pop == 0; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        end
        chk("pop_seen", n_pop, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        epoch    = 0;
        lat_max  = 1;
        n_pop    = 0;
        n_issue  = 0;
        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};
        vecs[3] = '{32'h0000_0FFD, 32'h0000_0FFC, 32'h0000_1000};

        // Reset state and streaming at one instruction per cycle
        apply_reset(3);
        first_issue_cyc = -1;
        first_valid_cyc = -1;
        cyc0 = cyc;
        repeat (14) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("first_issue_soon", {31'b0, (first_issue_cyc - cyc0) <= 2}, 32'h1);
        chk("first_valid_lat", first_valid_cyc - first_issue_cyc, 32'd2);
        chk("issue_rate", n_issue, cyc0 + 14 - first_issue_cyc);
        chk("pop_rate", n_pop, cyc0 + 14 - first_valid_cyc);
        chk("first_pc", first_pop_pc, 32'h0);

        // Stalled consumer: exactly DEPTH requests, then back-pressure
        drain(32'h0000_0200);
        n_issue = 0;
        repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("issues_ready_low", n_issue, DEPTH);
        chk("req_stalled", {31'b0, bus.imem_req_o}, 32'h0);
        n_issue = 0;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("resume", {31'b0, n_issue >= 2}, 32'h1);

        // Grant withheld: address and request held steady
        drain(32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("hold_addr", bus.imem_addr_o, 32'h0000_0300);
            chk("hold_req", {31'b0, bus.imem_req_o}, 32'h1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("after_grant_addr", bus.imem_addr_o, 32'h0000_0304);

        // Two requests in flight, then redirect to an unaligned target
        drain(32'h0000_0400);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
        chk("redir_addr", bus.imem_addr_o, 32'h0000_0100);
        chk("redir_valid", {31'b0, bus.instr_valid_o}, 32'h0);
        run_until_pop();
        chk("redir_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a pop while all slots are used
        drain(32'h0000_0500);
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0600, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", {31'b0, bus.instr_valid_o}, 32'h0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("stale_dropped", {31'b0, bus.instr_valid_o}, 32'h0);
        run_until_pop();
        chk("flush_first_pc", first_pop_pc, 32'h0000_0600);

        // Alignment and wrap-around of redirect targets
        for (int v = 0; v < 4; v++) begin
            drain(vecs[v].rpc);
            chk("vec_addr", bus.imem_addr_o, vecs[v].exp_addr);
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            chk("vec_next", bus.imem_addr_o, vecs[v].exp_next);
            run_until_pop();
            chk("vec_first_pc", first_pop_pc, vecs[v].exp_addr);
        end

        // Random latency, grant, back-pressure and redirects, reset mid-burst
        lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                apply_reset(2);
            end else begin
                step(($urandom_range(0, 31) == 0), $urandom, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            end
        end
        drain(32'h0000_0040);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
